// File: rtl/lvlshift_down_filter.sv
// Synchronises and glitch-filters NCH level-shifted 5V status lines, emitting rise/fall pulses.
// Optional sticky status/irq logic is built only when LVLSHIFT_FILTER_IRQ_EN is defined.
module lvlshift_down_filter #(
    parameter int NCH = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W = 8,
    parameter logic [NCH-1:0] RESET_VAL = {NCH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    yl_in,
    input  logic [NCH-1:0]    en,
    input  logic [FILT_W-1:0] filt_cnt,
    output logic [NCH-1:0]    y_out,
    output logic [NCH-1:0]    rise,
    output logic [NCH-1:0]    fall,
    input  logic [NCH-1:0]    clr,
    input  logic [NCH-1:0]    irq_mask,
    output logic [NCH-1:0]    status,
    output logic              irq
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } fstate_t;

    localparam logic [FILT_W-1:0] CNT_ZERO = {FILT_W{1'b0}};
    localparam logic [FILT_W-1:0] CNT_ONE  = FILT_W'(1'b1);

    logic [NCH-1:0] sync_r [SYNC_STAGES];
    logic [NCH-1:0] s_s;

    // Synchroniser chain; runs regardless of en so the filter always sees fresh samples
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= RESET_VAL;
            end
        end else begin
            sync_r[0] <= yl_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign s_s = sync_r[SYNC_STAGES-1];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        fstate_t           state_r;
        logic [FILT_W-1:0] cnt_r;
        logic              y_r;
        logic              rise_r;
        logic              fall_r;

        // Per-channel qualify FSM: y_r moves only after filt_cnt+1 consecutive mismatching samples
        always_ff @(posedge clk) begin
            if (reset) begin
                state_r <= ST_STABLE;
                cnt_r   <= CNT_ZERO;
                y_r     <= RESET_VAL[i];
                rise_r  <= 1'b0;
                fall_r  <= 1'b0;
            end else begin
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                if (!en[i]) begin
                    state_r <= ST_STABLE;
                    cnt_r   <= CNT_ZERO;
                end else begin
                    case (state_r)
                        ST_STABLE: begin
                            cnt_r <= CNT_ZERO;
                            if (s_s[i] != y_r) begin
                                if (filt_cnt == CNT_ZERO) begin
                                    y_r    <= s_s[i];
                                    rise_r <= s_s[i];
                                    fall_r <= ~s_s[i];
                                end else begin
                                    state_r <= ST_QUALIFY;
                                    cnt_r   <= CNT_ONE;
                                end
                            end
                        end
                        ST_QUALIFY: begin
                            if (s_s[i] == y_r) begin
                                state_r <= ST_STABLE;
                                cnt_r   <= CNT_ZERO;
                            end else if (cnt_r >= filt_cnt) begin
                                // >= so a lowered filt_cnt completes immediately instead of wrapping
                                y_r     <= s_s[i];
                                rise_r  <= s_s[i];
                                fall_r  <= ~s_s[i];
                                state_r <= ST_STABLE;
                                cnt_r   <= CNT_ZERO;
                            end else begin
                                cnt_r <= cnt_r + CNT_ONE;
                            end
                        end
                        default: begin
                            state_r <= ST_STABLE;
                            cnt_r   <= CNT_ZERO;
                        end
                    endcase
                end
            end
        end

        assign y_out[i] = y_r;
        assign rise[i]  = rise_r;
        assign fall[i]  = fall_r;
    end

`ifdef LVLSHIFT_FILTER_IRQ_EN
    logic [NCH-1:0] status_r;
    logic           irq_r;

    // Sticky event flags (a new event beats a same-cycle clear) and masked interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            status_r <= {NCH{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            status_r <= (status_r & ~clr) | rise | fall;
            irq_r    <= |(status_r & irq_mask);
        end
    end

    assign status = status_r;
    assign irq    = irq_r;
`else
    logic unused_irq_s;

    assign unused_irq_s = ^{clr, irq_mask};
    assign status       = {NCH{1'b0}};
    assign irq          = 1'b0;
`endif

endmodule
